// File: rtl/alu_sched_pkg.sv
// Shared state type and field widths for the ALU scheduler slice.
package alu_sched_pkg;

    localparam int unsigned ALU_FW    = 4;
    localparam int unsigned ALU_FLAGW = 4;
    localparam int unsigned OPS_CNTW  = 16;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } sched_state_e;

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first valid requester at or after ptr, modulo NREQ.
module rr_pick #(
    parameter int unsigned  NREQ = 4,
    localparam int unsigned IDW  = $clog2(NREQ)
) (
    input  logic [NREQ-1:0] req_valid,
    input  logic [IDW-1:0]  ptr,
    output logic [NREQ-1:0] grant,
    output logic [IDW-1:0]  grant_idx,
    output logic            any_valid
);

    logic [IDW:0]   sum;
    logic [IDW-1:0] idx;

    always_comb begin
        grant     = '0;
        grant_idx = '0;
        any_valid = 1'b0;
        sum       = '0;
        idx       = '0;
        for (int k = 0; k < NREQ; k++) begin
            // One extra bit so ptr + k never overflows before the modulo fold.
            sum = {1'b0, ptr} + (IDW + 1)'(k);
            if (sum >= (IDW + 1)'(NREQ)) begin
                sum = sum - (IDW + 1)'(NREQ);
            end
            idx = sum[IDW-1:0];
            if (!any_valid && req_valid[idx]) begin
                any_valid  = 1'b1;
                grant[idx] = 1'b1;
                grant_idx  = idx;
            end
        end
    end

endmodule

// File: rtl/alu_scheduler.sv
// Time-shares one external combinational ALU between NREQ requesters with round-robin
// arbitration and returns each result tagged with the requester ID.
module alu_scheduler
    import alu_sched_pkg::*;
#(
    parameter int unsigned  NREQ  = 4,
    parameter int unsigned  WIDTH = 32,
    localparam int unsigned IDW   = $clog2(NREQ)
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [NREQ-1:0]          req_valid,
    output logic [NREQ-1:0]          req_ready,
    input  logic [NREQ*WIDTH-1:0]    req_a,
    input  logic [NREQ*WIDTH-1:0]    req_b,
    input  logic [NREQ*ALU_FW-1:0]   req_f,
    output logic [WIDTH-1:0]         alu_a,
    output logic [WIDTH-1:0]         alu_b,
    output logic [ALU_FW-1:0]        alu_f,
    input  logic [WIDTH-1:0]         alu_y,
    input  logic [ALU_FLAGW-1:0]     alu_zero,
    output logic                     rsp_valid,
    input  logic                     rsp_ready,
    output logic [IDW-1:0]           rsp_id,
    output logic [WIDTH-1:0]         rsp_y,
    output logic [ALU_FLAGW-1:0]     rsp_zero,
    output logic [OPS_CNTW-1:0]      ops_done
);

    sched_state_e    state_q, state_d;
    logic [IDW-1:0]  ptr_q, ptr_d;
    logic [NREQ-1:0] grant;
    logic [IDW-1:0]  grant_idx;
    logic            any_valid;
    logic            accept;
    logic            rsp_done;

    logic [WIDTH-1:0]  sel_a, sel_b;
    logic [ALU_FW-1:0] sel_f;

    rr_pick #(
        .NREQ(NREQ)
    ) u_rr_pick (
        .req_valid(req_valid),
        .ptr      (ptr_q),
        .grant    (grant),
        .grant_idx(grant_idx),
        .any_valid(any_valid)
    );

    // One-hot operand mux keyed by the grant vector.
    always_comb begin
        sel_a = '0;
        sel_b = '0;
        sel_f = '0;
        for (int unsigned i = 0; i < NREQ; i++) begin
            if (grant[i]) begin
                sel_a = req_a[i*WIDTH +: WIDTH];
                sel_b = req_b[i*WIDTH +: WIDTH];
                sel_f = req_f[i*ALU_FW +: ALU_FW];
            end
        end
    end

    assign ptr_d = (grant_idx == IDW'(NREQ - 1)) ? '0 : grant_idx + IDW'(1);

    // Ready is held low while reset is asserted so nothing appears accepted.
    always_comb begin
        state_d   = state_q;
        req_ready = '0;
        accept    = 1'b0;
        rsp_done  = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (reset && any_valid) begin
                    req_ready = grant;
                    accept    = 1'b1;
                    state_d   = EXEC;
                end
            end
            EXEC: state_d = RESP;
            RESP: begin
                if (rsp_ready) begin
                    rsp_done = 1'b1;
                    state_d  = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign rsp_valid = (state_q == RESP);

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q  <= IDLE;
            ptr_q    <= '0;
            alu_a    <= '0;
            alu_b    <= '0;
            alu_f    <= '0;
            rsp_id   <= '0;
            rsp_y    <= '0;
            rsp_zero <= '0;
            ops_done <= '0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                alu_a  <= sel_a;
                alu_b  <= sel_b;
                alu_f  <= sel_f;
                rsp_id <= grant_idx;
                ptr_q  <= ptr_d;
            end
            if (state_q == EXEC) begin
                rsp_y    <= alu_y;
                rsp_zero <= alu_zero;
            end
            if (rsp_done) begin
                ops_done <= ops_done + OPS_CNTW'(1);
            end
        end
    end

endmodule

// File: doc/alu_scheduler.md
# alu_scheduler

Shares one combinational 32-bit ALU (`alu(a, b, f, y, zero)`) between `NREQ` independent requesters. It accepts one operation at a time through a per-requester valid/ready handshake, chosen by round-robin arbitration. It registers the operands into the ALU and captures the result. It returns the result with the requester's ID on a single response channel with backpressure. It sits between the ALU and the requesting units, for example the sequencer and the address-generation logic.

## Interface
- `NREQ`, 4: number of requesters, at least 2.
- `WIDTH`, 32: operand and result width.
- `IDW`, `$clog2(NREQ)`: requester ID width (derived).
- `clk`  in  1  clock.
- `reset`  in  1  reset, synchronous, active-low.
- `req_valid`  in  NREQ  bit i: requester i presents an operation.
- `req_ready`  out  NREQ  bit i: requester i's operation is accepted this cycle.
- `req_a`  in  NREQ*WIDTH  operand A, requester i in slice [i*WIDTH +: WIDTH].
- `req_b`  in  NREQ*WIDTH  operand B, same slicing.
- `req_f`  in  NREQ*4  ALU function code, requester i in slice [i*4 +: 4].
- `alu_a`, `alu_b`  out  WIDTH  registered operands to the ALU.
- `alu_f`  out  4  registered function code to the ALU.
- `alu_y`  in  WIDTH  ALU result.
- `alu_zero`  in  4  ALU status flags, passed through unchanged.
- `rsp_valid`  out  1  response available.
- `rsp_ready`  in  1  consumer accepts the response.
- `rsp_id`  out  IDW  index of the requester that issued the operation.
- `rsp_y`  out  WIDTH  captured result.
- `rsp_zero`  out  4  captured flags.
- `ops_done`  out  16  count of completed responses; wraps at 16'hFFFF to 0.

## Operation
- FSM states: IDLE, EXEC, RESP.
- IDLE:
  - Grant g is the first index with `req_valid` set, searching from pointer `ptr` upward modulo NREQ.
  - `req_ready[g]` = 1 combinationally; every other ready bit is 0.
  - On the handshake, latch `req_a/b/f` slice g into `alu_a/b/f` and latch g into `rsp_id`, then go to EXEC.
  - `ptr` ← (g+1) mod NREQ. The pointer wraps from NREQ-1 to 0.
  - With no valid bit set: stay in IDLE, all ready bits 0, `ptr` unchanged.
- EXEC:
  - Capture `alu_y` into `rsp_y` and `alu_zero` into `rsp_zero`, then go to RESP.
  - All ready bits are 0.
- RESP:
  - `rsp_valid` = 1.
  - Hold `rsp_id`, `rsp_y` and `rsp_zero` stable until `rsp_ready` = 1.
  - On the handshake: `ops_done` += 1 and return to IDLE.
  - All ready bits are 0 in this state. No new request is accepted in the same cycle as the response handshake.
- Requester obligation: once `req_valid` is raised, hold it and its payload stable until `req_ready` is seen. The scheduler does not check this.
- A requester that drops `req_valid` before it is granted is simply skipped.
- `req_ready` depends only on the state, `req_valid` and `ptr`. There is no combinational path from `rsp_ready` to `req_ready`.
- Reset (`reset` = 0 at a clk edge):
  - State goes to IDLE and `ptr` = 0.
  - Outputs go to: `rsp_valid` 0, `req_ready` all 0, `rsp_id` 0, `rsp_y` 0, `rsp_zero` 0, `alu_a/b/f` 0, `ops_done` 0.
  - Reset mid-operation discards the in-flight operation. No response is produced for it and `ops_done` is not incremented.

## Timing
- Accept at edge T (IDLE handshake) → `alu_*` valid after T → result captured at T+1 → `rsp_valid` high after T+1.
- Minimum latency is 2 cycles from accept to `rsp_valid`.
- Peak throughput is one operation per 3 cycles, when `rsp_ready` is held high.
- The ALU is given one full cycle to settle. It must be purely combinational with less than one cycle of delay.
- Fairness: under continuous requests from all requesters, each is granted once every NREQ operations.

## Structure
- Package `alu_sched_pkg` holds:
  - the state enum (IDLE, EXEC, RESP);
  - `ALU_FW` = 4 (function-code width);
  - `ALU_FLAGW` = 4 (flag width);
  - `OPS_CNTW` = 16 (counter width).
- Sub-module `rr_pick` is combinational: inputs `req_valid` and `ptr`; outputs one-hot grant, grant index and `any_valid`. It is parameterized by NREQ.
- The FSM, operand/result registers, pointer and counter live in `alu_scheduler`.
- The ALU is instantiated outside `alu_scheduler`.

## Test plan
The bench uses its own ALU model with f=4'h2 meaning add and f=4'h6 meaning subtract; `zero[0]` is set when y == 0.
- Single request: requester 2 sends a=32'h5, b=32'h7, f=4'h2 with `rsp_ready` held at 1. `req_ready[2]` rises in the first IDLE cycle. Two cycles later: `rsp_valid` = 1, `rsp_id` = 2, `rsp_y` = 32'hC, `ops_done` = 1.
- Round-robin order: all four requesters valid continuously from reset. The grant order is 0,1,2,3,0, and `rsp_id` follows the same sequence.
- Pointer wrap: after requester 3 is served, only requesters 1 and 3 remain valid. Requester 1 is granted first.
- Backpressure: hold `rsp_ready` = 0 for 5 cycles with a=b=32'h9, f=4'h6. `rsp_valid` stays 1 and `rsp_y` = 0 and `rsp_zero[0]` = 1 stay stable. `req_ready` stays all 0 throughout. Exactly one `ops_done` increment occurs after release.
- Reset mid-operation: assert `reset` = 0 during EXEC. The next cycle shows all outputs at their reset values. No response appears, `ops_done` = 0, and the next grant goes to the lowest valid index.
- Counter wrap: preload 65535 responses (or force the counter to 16'hFFFF). One more response gives `ops_done` = 0.
